// File: rtl/pipeline_run_controller.sv
// Run/step/drain sequencer driving the common stage hold of the 5-stage pipeline; optional watchdog under PIPE_WATCHDOG_EN.
// Latency: a command accepted at edge N affects o_halt from cycle N+1; flush and step-done pulses are registered (1 cycle).
// Backpressure: o_cmd_ready is low in STEP and DRAIN, so the debug unit holds its command until IDLE, RUN or DONE.
module pipeline_run_controller #(
    parameter int NB_CNT      = 32,
    parameter int DRAIN_DEPTH = 3,
    parameter int MAX_CYCLES  = 2**20
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    output logic              o_cmd_ready,
    input  logic              i_halt_instr_ID,
    output logic              o_halt,
    output logic              o_pipe_flush,
    output logic              o_running,
    output logic              o_step_done,
    output logic              o_done,
    output logic              o_timeout,
    output logic [NB_CNT-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_FLUSH = 2'b11;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_DEPTH);

    state_t              state, state_next;
    logic [3:0]          drain_cnt, drain_next;
    logic [NB_CNT-1:0]   cycle_cnt;
    logic                flush_q, flush_next;
    logic                step_done_q, step_done_next;
    logic                clear_cnt;
    logic                cmd_fire;
    logic                active;
    logic                timeout_q, timeout_set, timeout_clr;

    assign active      = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
    assign o_cmd_ready = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_DONE);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            drain_cnt   <= 4'd0;
            flush_q     <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state       <= state_next;
            drain_cnt   <= drain_next;
            flush_q     <= flush_next;
            step_done_q <= step_done_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_next     = drain_cnt;
        flush_next     = 1'b0;
        step_done_next = 1'b0;
        clear_cnt      = 1'b0;
        timeout_set    = 1'b0;
        timeout_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (i_cmd)
                        CMD_RUN:   state_next = ST_RUN;
                        CMD_STEP:  state_next = ST_STEP;
                        CMD_FLUSH: begin
                            flush_next = 1'b1;
                            clear_cnt  = 1'b1;
                        end
                        default:   state_next = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                // HALT in ID beats a concurrent STOP; the STOP is consumed.
                if (i_halt_instr_ID) begin
                    state_next = ST_DRAIN;
                    drain_next = DRAIN_LOAD;
                end else if (cmd_fire && i_cmd == CMD_STOP) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (i_halt_instr_ID) begin
                    state_next = ST_DRAIN;
                    drain_next = DRAIN_LOAD;
                end else begin
                    state_next     = ST_IDLE;
                    step_done_next = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt <= 4'd1) begin
                    state_next = ST_DONE;
                    drain_next = 4'd0;
                end else begin
                    drain_next = drain_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                if (cmd_fire && i_cmd == CMD_FLUSH) begin
                    state_next  = ST_IDLE;
                    flush_next  = 1'b1;
                    clear_cnt   = 1'b1;
                    timeout_clr = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
`ifdef PIPE_WATCHDOG_EN
        // The advancing cycle that brings the count to MAX_CYCLES is the last one.
        if (active && cycle_cnt == NB_CNT'(MAX_CYCLES - 1)) begin
            state_next  = ST_DONE;
            drain_next  = 4'd0;
            timeout_set = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cycle_cnt <= '0;
        end else if (clear_cnt) begin
            cycle_cnt <= '0;
        end else if (active && cycle_cnt != {NB_CNT{1'b1}}) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

`ifdef PIPE_WATCHDOG_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timeout_q <= 1'b0;
        end else if (timeout_clr) begin
            timeout_q <= 1'b0;
        end else if (timeout_set) begin
            timeout_q <= 1'b1;
        end
    end
`else
    logic unused_wd;
    assign unused_wd = timeout_set ^ timeout_clr;
    assign timeout_q = 1'b0;
`endif

    assign o_halt        = !active;
    assign o_running     = (state == ST_RUN) || (state == ST_DRAIN);
    assign o_done        = (state == ST_DONE);
    assign o_pipe_flush  = flush_q;
    assign o_step_done   = step_done_q;
    assign o_timeout     = timeout_q;
    assign o_cycle_count = cycle_cnt;

endmodule
